// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-register widths and the MEM/WB field layout {WRITE_ENABLE, MUXDATAMEM_SELECT, RD, ALU_OUT, DATA_OUT}
package pipe_pkg;
  localparam int IF_ID_W = 64;
  localparam int ID_EX_W = 155;
  localparam int EX_MEM_W = 106;
  localparam int MEM_WB_W = 71;
  localparam int MW_DATA_OUT_LSB = 0;
  localparam int MW_ALU_OUT_LSB = 32;
  localparam int MW_RD_LSB = 64;
  localparam int MW_MUXDATAMEM_SELECT = 69;
  localparam int MW_WRITE_ENABLE = 70;
  function automatic logic [MEM_WB_W-1:0] pack_mem_wb(input logic we, input logic sel, input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] data);
    return {we, sel, rd, alu, data};
  endfunction
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones; ports clk, rst_n (async active-low), en, cnt
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage (optional 2-entry skid) with flush, occupancy and saturating stall counter; ports CLK, RESET(async low), IN_VALID/IN_DATA/IN_READY, OUT_VALID/OUT_DATA/OUT_READY, FLUSH, OCCUPANCY, STALL_CNT
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                SKID       = 0,
  parameter int                CNT_W      = 16,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OUT_DATA,
  input  logic              OUT_READY,
  input  logic              FLUSH,
  output logic [1:0]        OCCUPANCY,
  output logic [CNT_W-1:0]  STALL_CNT
);
  logic              main_valid, skid_valid, accept, consume;
  logic [DATA_W-1:0] main_data, skid_data;
  assign IN_READY  = (SKID != 0) ? ~skid_valid : (~main_valid | OUT_READY);
  assign accept    = IN_VALID & IN_READY;
  assign consume   = main_valid & OUT_READY;
  assign OUT_VALID = main_valid;
  assign OUT_DATA  = main_data;
  assign OCCUPANCY = {1'b0, main_valid} + {1'b0, skid_valid};
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= RESET_DATA;
      skid_data  <= RESET_DATA;
    end else if (FLUSH) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= RESET_DATA;
      skid_data  <= RESET_DATA;
    end else if (skid_valid) begin
      if (consume) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (accept && (!main_valid || OUT_READY)) begin
      main_data  <= IN_DATA;
      main_valid <= 1'b1;
    end else if (accept) begin
      skid_data  <= IN_DATA;
      skid_valid <= 1'b1;
    end else if (consume) main_valid <= 1'b0;
  sat_counter #(.W(CNT_W)) u_stall (
    .clk  (CLK),
    .rst_n(RESET),
    .en   (main_valid & ~OUT_READY),
    .cnt  (STALL_CNT)
  );
endmodule
